// File: rtl/sram_nblk_pkg.sv
// sram_nblk_pkg
//   Shared definitions for the multi-bank DA LUT memory:
//   - load/run state encoding
//   - bank-select width derivation used by the top-level parameter list

package sram_nblk_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_LOAD = LOAD,
    ST_RUN  = RUN
  } state_t;

  // Bank-select width: at least one bit, even for a single bank.
  function automatic int calc_bw(input int nblk);
    return (nblk <= 2) ? 1 : $clog2(nblk);
  endfunction

endpackage

// File: rtl/sram_nblk_bank.sv
// sram_bank
//   One LUT bank: synchronous RAM, one write port and one read port on the
//   same clock. The read is registered and read-first (a same-address write
//   in the same cycle returns the old word). The array has no reset.
// Ports:
//   clk         clock
//   we/waddr/wdata   write enable, word address, write data
//   re/raddr    read enable and word address
//   rdata       registered read data (updates only when re=1)

module sram_bank #(
  parameter int DW = 20,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sram_nblk.sv
// sram_nblk
//   NBLK-bank lookup memory for the distributed-arithmetic FIR. Tables are
//   filled through a ready/valid load port while in LOAD; in RUN all banks
//   are read in parallel with a fixed three-register latency.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse: enter LOAD (ignored while already loading)
//   ld_valid/ld_ready load handshake; ld_ready is high exactly in LOAD
//   ld_addr           {bank, word} write address
//   ld_data           write data
//   ld_bcast          write the word to every bank (bank field ignored)
//   ld_last           final beat; moves the FSM to RUN
//   rd_valid/rd_addr  read request and per-bank word addresses
//   q/q_valid         per-bank read data and its valid strobe
//   loaded            tables valid (RUN)
//   ld_count          accepted beats since last start, saturating
//   ld_err            sticky: a non-broadcast beat addressed a missing bank

module sram_nblk
  import sram_nblk_pkg::*;
#(
  parameter int NBLK = 8,
  parameter int AW   = 8,
  parameter int DW   = 20,
  parameter int BW   = calc_bw(NBLK)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [BW+AW-1:0]   ld_addr,
  input  logic [DW-1:0]      ld_data,
  input  logic               ld_bcast,
  input  logic               ld_last,
  input  logic               rd_valid,
  input  logic [NBLK*AW-1:0] rd_addr,
  output logic [NBLK*DW-1:0] q,
  output logic               q_valid,
  output logic               loaded,
  output logic [AW+BW:0]     ld_count,
  output logic               ld_err
);

  localparam logic [AW+BW:0] CNT_ONE = 1;

  state_t             state_reg;
  logic               ld_ready_reg;
  logic               loaded_reg;
  logic [AW+BW:0]     ld_count_reg;
  logic               ld_err_reg;

  logic               ld_accept;
  logic [BW-1:0]      ld_bank;
  logic [AW-1:0]      ld_word;
  logic               ld_bad;
  logic [NBLK-1:0]    ld_sel;

  logic               wr_vld_reg;
  logic [NBLK-1:0]    wr_sel_reg;
  logic [AW-1:0]      wr_word_reg;
  logic [DW-1:0]      wr_data_reg;

  logic               rd_acc;
  logic               rd_vld_s1_reg;
  logic               rd_vld_s2_reg;
  logic [NBLK*AW-1:0] rd_addr_s1_reg;
  logic [NBLK*DW-1:0] bank_q;
  logic [NBLK*DW-1:0] q_reg;
  logic               q_valid_reg;

  assign ld_accept = ld_valid & ld_ready_reg;
  assign ld_bank   = ld_addr[AW +: BW];
  assign ld_word   = ld_addr[AW-1:0];
  // The bank field can encode more banks than exist when NBLK is not a
  // power of two; broadcast beats never look at it.
  assign ld_bad    = !ld_bcast && (int'(ld_bank) >= NBLK);

  // Load/run FSM. ld_ready and loaded are registered alongside the state so
  // they always equal (state == LOAD) and (state == RUN).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      ld_ready_reg <= 1'b0;
      loaded_reg   <= 1'b0;
      ld_count_reg <= '0;
      ld_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_RUN: begin
          if (start) begin
            state_reg    <= ST_LOAD;
            ld_ready_reg <= 1'b1;
            loaded_reg   <= 1'b0;
            ld_count_reg <= '0;
            ld_err_reg   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (ld_accept) begin
            if (ld_count_reg != '1) begin
              ld_count_reg <= ld_count_reg + CNT_ONE;
            end
            if (ld_bad) begin
              ld_err_reg <= 1'b1;
            end
            if (ld_last) begin
              state_reg    <= ST_RUN;
              ld_ready_reg <= 1'b0;
              loaded_reg   <= 1'b1;
            end
          end
        end
        default: begin
          state_reg    <= ST_IDLE;
          ld_ready_reg <= 1'b0;
          loaded_reg   <= 1'b0;
        end
      endcase
    end
  end

  // Accepted beats are registered and written one cycle later; a bad-bank
  // beat leaves wr_sel_reg all-zero so nothing is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_vld_reg  <= 1'b0;
      wr_sel_reg  <= '0;
      wr_word_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_vld_reg <= ld_accept;
      if (ld_accept) begin
        wr_sel_reg  <= ld_sel;
        wr_word_reg <= ld_word;
        wr_data_reg <= ld_data;
      end
    end
  end

  // Read pipeline: address register, bank read, output register. Once a
  // read is accepted it runs to completion regardless of later state.
  assign rd_acc = rd_valid & loaded_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_s1_reg  <= 1'b0;
      rd_vld_s2_reg  <= 1'b0;
      rd_addr_s1_reg <= '0;
      q_valid_reg    <= 1'b0;
      q_reg          <= '0;
    end else begin
      rd_vld_s1_reg <= rd_acc;
      rd_vld_s2_reg <= rd_vld_s1_reg;
      q_valid_reg   <= rd_vld_s2_reg;
      if (rd_acc) begin
        rd_addr_s1_reg <= rd_addr;
      end
      if (rd_vld_s2_reg) begin
        q_reg <= bank_q;
      end
    end
  end

  for (genvar gi = 0; gi < NBLK; gi++) begin : g_bank
    assign ld_sel[gi] = ld_bcast | (ld_bank == BW'(gi));

    sram_bank #(
      .DW(DW),
      .AW(AW)
    ) u_bank (
      .clk   (clk),
      .we    (wr_vld_reg & wr_sel_reg[gi]),
      .waddr (wr_word_reg),
      .wdata (wr_data_reg),
      .re    (rd_vld_s1_reg),
      .raddr (rd_addr_s1_reg[gi*AW +: AW]),
      .rdata (bank_q[gi*DW +: DW])
    );
  end

  assign ld_ready = ld_ready_reg;
  assign loaded   = loaded_reg;
  assign ld_count = ld_count_reg;
  assign ld_err   = ld_err_reg;
  assign q        = q_reg;
  assign q_valid  = q_valid_reg;

endmodule

// File: tb/tb_sram_nblk.sv
// tb_sram_nblk
//   Bench for sram_nblk: an 8-bank instance driven against a scoreboard of
//   expected read words, and a 5-bank instance for out-of-range bank beats.

module tb_sram_nblk;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bank instance
  logic          start = 0, ld_valid = 0, ld_bcast = 0, ld_last = 0, rd_valid = 0;
  logic [10:0]   ld_addr = '0;
  logic [19:0]   ld_data = '0;
  logic [63:0]   rd_addr = '0;
  logic          ld_ready, q_valid, loaded, ld_err;
  logic [159:0]  q;
  logic [11:0]   ld_count;

  // 5-bank instance
  logic          b_start = 0, b_ld_valid = 0, b_ld_bcast = 0, b_ld_last = 0, b_rd_valid = 0;
  logic [10:0]   b_ld_addr = '0;
  logic [19:0]   b_ld_data = '0;
  logic [39:0]   b_rd_addr = '0;
  logic          b_ld_ready, b_q_valid, b_loaded, b_ld_err;
  logic [99:0]   b_q;
  logic [11:0]   b_ld_count;

  sram_nblk #(.NBLK(8), .AW(8), .DW(20)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_bcast(ld_bcast), .ld_last(ld_last),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .q(q), .q_valid(q_valid), .loaded(loaded),
    .ld_count(ld_count), .ld_err(ld_err)
  );

  sram_nblk #(.NBLK(5), .AW(8), .DW(20)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .ld_valid(b_ld_valid), .ld_ready(b_ld_ready),
    .ld_addr(b_ld_addr), .ld_data(b_ld_data), .ld_bcast(b_ld_bcast), .ld_last(b_ld_last),
    .rd_valid(b_rd_valid), .rd_addr(b_rd_addr), .q(b_q), .q_valid(b_q_valid), .loaded(b_loaded),
    .ld_count(b_ld_count), .ld_err(b_ld_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_qv     = 0;
  logic [159:0] sb [$];
  logic [19:0]  model [8][256];
  logic [63:0]  ra;
  logic [159:0] mon_exp;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One load beat on the 8-bank instance; ld_valid is left asserted.
  task automatic beat(input logic [10:0] a, input logic [19:0] d, input logic bc, input logic last);
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_bcast = bc; ld_last = last;
    check_eq("ld_ready_in_load", ld_ready, 1'b1);
    tick();
    if (bc) begin
      for (int i = 0; i < 8; i++) model[i][a[7:0]] = d;
    end else begin
      model[a[10:8]][a[7:0]] = d;
    end
    $display("load beat addr=%h data=%h bcast=%0d last=%0d", a, d, bc, last);
  endtask

  // Drive one read cycle; push the expected word when it should be accepted.
  task automatic rd_push(input logic [63:0] addrs, input bit accept);
    logic [159:0] e;
    rd_valid = 1'b1;
    rd_addr  = addrs;
    if (accept) begin
      for (int i = 0; i < 8; i++) e[i*20 +: 20] = model[i][addrs[i*8 +: 8]];
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic drain(input string tag);
    int t = 0;
    rd_valid = 1'b0;
    while (sb.size() != 0 && t < 20) begin
      tick();
      t++;
    end
    check_eq(tag, sb.size(), 0);
    repeat (3) tick();
  endtask

  // Scoreboard monitor for the 8-bank instance.
  always @(negedge clk) begin
    if (rst_n && q_valid) begin
      n_qv++;
      if (sb.size() == 0) begin
        check_eq("q_unexpected", q_valid, 1'b0);
      end else begin
        mon_exp = sb.pop_front();
        check_eq("q_data", q, mon_exp);
        $display("read q=%h", q);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int qv0;

    // Reset state
    repeat (3) tick();
    check_eq("rst_ld_ready", ld_ready, 1'b0);
    check_eq("rst_q", q, '0);
    check_eq("rst_q_valid", q_valid, 1'b0);
    check_eq("rst_loaded", loaded, 1'b0);
    check_eq("rst_ld_count", ld_count, 0);
    check_eq("rst_ld_err", ld_err, 1'b0);
    rst_n = 1'b1;

    // Reads in IDLE are dropped
    rd_addr = '0;
    rd_valid = 1'b1;
    repeat (4) tick();
    rd_valid = 1'b0;
    repeat (4) tick();
    check_eq("idle_gate_qv", n_qv, 0);

    // Reset in the middle of a load
    pulse_start();
    check_eq("start_ld_ready", ld_ready, 1'b1);
    for (int i = 0; i < 3; i++) beat(11'(i), 20'(i), 1'b0, 1'b0);
    check_eq("midload_count", ld_count, 3);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_ld_ready", ld_ready, 1'b0);
    check_eq("mrst_loaded", loaded, 1'b0);
    check_eq("mrst_ld_count", ld_count, 0);
    check_eq("mrst_q_valid", q_valid, 1'b0);
    check_eq("mrst_q", q, '0);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("post_rst_ld_ready", ld_ready, 1'b0);

    // Full load; reads held high throughout LOAD must be dropped
    pulse_start();
    rd_addr = {8{8'hFF}};
    rd_valid = 1'b1;
    for (int a = 0; a < 2048; a++) beat(11'(a), 20'(a) ^ 20'hA5A5A, 1'b0, a == 2047);
    ld_valid = 1'b0;
    ld_last = 1'b0;
    check_eq("full_loaded", loaded, 1'b1);
    check_eq("full_count", ld_count, 2048);
    check_eq("load_gate_qv", n_qv, 0);
    // first read right after the last accept sees the just-written word
    rd_push({8{8'hFF}}, 1'b1);

    // Back-to-back readback of every {bank, word}
    for (int w = 0; w < 256; w++) begin
      for (int i = 0; i < 8; i++) ra[i*8 +: 8] = 8'(w + i*37);
      rd_push(ra, 1'b1);
    end
    drain("readback_drain");

    // Broadcast beat
    pulse_start();
    check_eq("bc_start_count", ld_count, 0);
    check_eq("bc_start_loaded", loaded, 1'b0);
    beat({3'd5, 8'h3C}, 20'h12345, 1'b1, 1'b1);
    ld_valid = 1'b0; ld_bcast = 1'b0; ld_last = 1'b0;
    check_eq("bc_count", ld_count, 1);
    rd_push({8{8'h3D}}, 1'b1);
    rd_push({8{8'h3C}}, 1'b1);
    drain("bcast_drain");
    check_eq("bcast_q_hold", q, {8{20'h12345}});

    // Reload while three reads are in flight
    qv0 = n_qv;
    rd_push({8{8'h10}}, 1'b1);
    rd_push({8{8'h20}}, 1'b1);
    start = 1'b1;
    rd_push({8{8'h30}}, 1'b1);
    start = 1'b0;
    rd_push({8{8'h40}}, 1'b0);
    drain("reload_drain");
    check_eq("reload_qv_count", n_qv - qv0, 3);
    check_eq("reload_count", ld_count, 0);
    check_eq("reload_ld_ready", ld_ready, 1'b1);
    beat({3'd0, 8'h00}, 20'h0BEEF, 1'b0, 1'b1);
    ld_valid = 1'b0; ld_last = 1'b0;
    check_eq("reload_loaded", loaded, 1'b1);

    // Out-of-range bank on the 5-bank instance
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int b = 0; b < 5; b++) begin
      b_ld_valid = 1'b1;
      b_ld_addr = {3'(b), 8'h10};
      b_ld_data = 20'h100 + 20'(b);
      tick();
      $display("b5 load beat addr=%h data=%h", b_ld_addr, b_ld_data);
    end
    check_eq("b5_err_clean", b_ld_err, 1'b0);
    b_ld_addr = {3'd6, 8'h10};
    b_ld_data = 20'hFFFFF;
    b_ld_last = 1'b1;
    tick();
    $display("b5 load beat addr=%h data=%h last=1", b_ld_addr, b_ld_data);
    b_ld_valid = 1'b0;
    b_ld_last = 1'b0;
    check_eq("b5_err_set", b_ld_err, 1'b1);
    check_eq("b5_count", b_ld_count, 6);
    check_eq("b5_loaded", b_loaded, 1'b1);
    b_rd_valid = 1'b1;
    b_rd_addr = {5{8'h10}};
    tick();
    b_rd_valid = 1'b0;
    tick();
    tick();
    check_eq("b5_q_valid", b_q_valid, 1'b1);
    check_eq("b5_q", b_q, {20'h104, 20'h103, 20'h102, 20'h101, 20'h100});
    $display("b5 read q=%h", b_q);
    tick();
    check_eq("b5_q_valid_end", b_q_valid, 1'b0);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check_eq("b5_err_cleared", b_ld_err, 1'b0);
    check_eq("b5_count_cleared", b_ld_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
